// File: rtl/spi_pwm_cmd_frontend_pkg.sv
// -----------------------------------------------------------------------------
// spi_pwm_cmd_frontend_pkg
// Shared definitions for the SPI-to-PWM command front end: FSM state encoding,
// command byte field positions and the number of addressable PWM channels.
// -----------------------------------------------------------------------------
package spi_pwm_cmd_frontend_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CMD  = 3'd1,
      LOAD = 3'd2,
      DATA = 3'd3,
      DONE = 3'd4
   } state_t;

   // Command byte layout: [7] write/read, [6:3] reserved (must be 0), [2:0] address
   localparam int unsigned CMD_WR_BIT   = 7;
   localparam int unsigned CMD_RSVD_HI  = 6;
   localparam int unsigned CMD_RSVD_LO  = 3;
   localparam int unsigned CMD_ADDR_HI  = 2;
   localparam int unsigned CMD_ADDR_LO  = 0;

   // Channels 0..NUM_CHANNELS-1 exist; address 7 is a write sink / reads as 0
   localparam int unsigned NUM_CHANNELS = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings the asynchronous SPI pins into the clk domain and detects sclk edges.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   sclk, cs, mosi    raw SPI pins
//   cs_sync           synchronized chip select (active-low)
//   mosi_sync         synchronized MOSI
//   sclk_rise         one-clk pulse on a rising sclk edge
//   sclk_fall         one-clk pulse on a falling sclk edge
// -----------------------------------------------------------------------------
module spi_sync_edge
   import spi_pwm_cmd_frontend_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic sclk,
   input  logic cs,
   input  logic mosi,
   output logic cs_sync,
   output logic mosi_sync,
   output logic sclk_rise,
   output logic sclk_fall
);

   logic [SYNC_STAGES-1:0] sclk_sr;
   logic [SYNC_STAGES-1:0] cs_sr;
   logic [SYNC_STAGES-1:0] mosi_sr;
   logic                   sclk_d;

   // Size casts drop the oldest bit so the chain works for any depth >= 1
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sr <= '0;
         cs_sr   <= '0;
         mosi_sr <= '0;
         sclk_d  <= 1'b0;
      end else begin
         sclk_sr <= SYNC_STAGES'({sclk_sr, sclk});
         cs_sr   <= SYNC_STAGES'({cs_sr, cs});
         mosi_sr <= SYNC_STAGES'({mosi_sr, mosi});
         sclk_d  <= sclk_sr[SYNC_STAGES-1];
      end
   end

   assign cs_sync   = cs_sr[SYNC_STAGES-1];
   assign mosi_sync = mosi_sr[SYNC_STAGES-1];
   assign sclk_rise =  sclk_sr[SYNC_STAGES-1] & ~sclk_d;
   assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] &  sclk_d;

endmodule

// File: rtl/spi_pwm_cmd_frontend.sv
// -----------------------------------------------------------------------------
// spi_pwm_cmd_frontend
// SPI mode-0 slave that decodes 2-byte frames into PWM level writes or
// read-backs. Byte 0 is the command, byte 1 the data (write) or dummy (read,
// during which the selected level is shifted out on miso).
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   sclk, cs, mosi, miso   SPI pins (cs active-low)
//   wr_en       one-clk write strobe, with wr_addr / wr_data (held between strobes)
//   rd_addr     channel selected for read-back
//   rd_data     level of channel rd_addr (0 for index 7)
// -----------------------------------------------------------------------------
module spi_pwm_cmd_frontend
   import spi_pwm_cmd_frontend_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sclk,
   input  logic       cs,
   input  logic       mosi,
   output logic       miso,
   output logic       wr_en,
   output logic [2:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [2:0] rd_addr,
   input  logic [7:0] rd_data
);

   localparam logic [2:0] LAST_CH = 3'(NUM_CHANNELS - 1);

   logic       cs_s;
   logic       mosi_s;
   logic       sclk_rise;
   logic       sclk_fall;

   state_t     state;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic [7:0] tx_buf;
   logic       cmd_wr;
   logic [2:0] cmd_addr;
   logic       skip_fall;

   logic [7:0] rx_byte;
   logic       byte_done;

   spi_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .sclk      (sclk),
      .cs        (cs),
      .mosi      (mosi),
      .cs_sync   (cs_s),
      .mosi_sync (mosi_s),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall)
   );

   // Byte as it will stand after the current rising edge shifts in
   assign rx_byte   = {shreg[6:0], mosi_s};
   assign byte_done = sclk_rise && (bit_cnt == 3'd7);

   // miso is registered alongside tx_buf: each branch that changes tx_buf
   // also loads the bit that will be at tx_buf[7] afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         tx_buf    <= '0;
         cmd_wr    <= 1'b0;
         cmd_addr  <= '0;
         skip_fall <= 1'b0;
         miso      <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_addr   <= '0;
      end else if (cs_s) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         tx_buf    <= '0;
         skip_fall <= 1'b0;
         miso      <= 1'b0;
         wr_en     <= 1'b0;
      end else begin
         wr_en <= 1'b0;

         if (sclk_rise && state != DONE) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
         end

         case (state)
            IDLE: begin
               miso  <= 1'b0;
               state <= CMD;
            end
            CMD: begin
               miso <= 1'b0;
               if (byte_done) begin
                  cmd_wr   <= rx_byte[CMD_WR_BIT];
                  cmd_addr <= rx_byte[CMD_ADDR_HI:CMD_ADDR_LO];
                  rd_addr  <= rx_byte[CMD_ADDR_HI:CMD_ADDR_LO];
                  state    <= (|rx_byte[CMD_RSVD_HI:CMD_RSVD_LO]) ? DONE : LOAD;
               end
            end
            LOAD: begin
               tx_buf    <= cmd_wr ? 8'h00 : rd_data;
               miso      <= cmd_wr ? 1'b0  : rd_data[7];
               skip_fall <= 1'b1;
               state     <= DATA;
            end
            DATA: begin
               // The falling edge right after the command byte precedes the
               // first data bit, so the MSB must stay put for it.
               if (sclk_fall) begin
                  if (skip_fall) begin
                     skip_fall <= 1'b0;
                  end else begin
                     tx_buf <= {tx_buf[6:0], 1'b0};
                     miso   <= tx_buf[6];
                  end
               end
               if (byte_done) begin
                  miso  <= 1'b0;
                  state <= DONE;
                  if (cmd_wr && cmd_addr <= LAST_CH) begin
                     wr_en   <= 1'b1;
                     wr_addr <= cmd_addr;
                     wr_data <= rx_byte;
                  end
               end
            end
            DONE: begin
               miso <= 1'b0;
            end
            default: begin
               miso  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_pwm_cmd_frontend.sv
// -----------------------------------------------------------------------------
// tb_spi_pwm_cmd_frontend
// Directed SPI frames drive the front end; expected writes go into a queue
// that a monitor drains whenever wr_en is seen.
// -----------------------------------------------------------------------------
module tb_spi_pwm_cmd_frontend;

   localparam int HALF = 10; // clk cycles per sclk half-period

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       sclk;
   logic       cs;
   logic       mosi;
   logic       miso;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [2:0] rd_addr;
   logic [7:0] rd_data;

   int total  = 0;
   int passed = 0;

   wr_t exp_q[$];
   logic miso_zero_en = 1'b0;
   int   miso_viol    = 0;

   always #5 clk = ~clk;

   // Read-back model of the PWM level registers
   assign rd_data = (rd_addr == 3'd5) ? 8'hA5 :
                    (rd_addr == 3'd7) ? 8'h00 : {5'b0, rd_addr};

   spi_pwm_cmd_frontend #(
      .SYNC_STAGES(2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sclk    (sclk),
      .cs      (cs),
      .mosi    (mosi),
      .miso    (miso),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every wr_en cycle must match the next expected write
   always @(negedge clk) begin
      if (miso_zero_en && miso !== 1'b0) miso_viol++;
      if (wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_wr: got addr %0d data 0x%0h expected no write",
                     wr_addr, wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_txn", {21'b0, wr_addr, wr_data}, {21'b0, e.addr, e.data});
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      logic [7:0] t;
      t  = tx;
      rx = '0;
      for (int i = 0; i < n; i++) begin
         mosi = t[7];
         t    = {t[6:0], 1'b0};
         clks(HALF);
         rx   = {rx[6:0], miso};
         sclk = 1'b1;
         clks(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input int nbytes,
                        output logic [7:0] rx1);
      logic [7:0] rx;
      cs = 1'b0;
      clks(HALF);
      spi_bits(b0, 8, rx);
      spi_bits(b1, 8, rx1);
      if (nbytes > 2) spi_bits(b2, 8, rx);
      clks(HALF);
      cs   = 1'b1;
      mosi = 1'b0;
      clks(20);
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      check({tag, "_wr_en"},   {31'b0, wr_en},   32'd0);
      check({tag, "_wr_addr"}, {29'b0, wr_addr}, 32'd0);
      check({tag, "_wr_data"}, {24'b0, wr_data}, 32'd0);
      check({tag, "_rd_addr"}, {29'b0, rd_addr}, 32'd0);
      check({tag, "_miso"},    {31'b0, miso},    32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] rx;
      reset = 1'b1;
      cs    = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b0;
      clks(5);
      check_reset_outputs("rst");
      reset = 1'b0;
      clks(10);

      // Write 0x83, 0x40
      miso_zero_en = 1'b1;
      exp_q.push_back('{addr: 3'd3, data: 8'h40});
      frame(8'h83, 8'h40, 8'h00, 2, rx);
      check("wr3_pending", exp_q.size(), 32'd0);
      check("wr3_miso_zero", miso_viol, 32'd0);
      miso_zero_en = 1'b0;
      miso_viol    = 0;

      // Read address 5
      frame(8'h05, 8'h00, 8'h00, 2, rx);
      check("rd5_rd_addr", {29'b0, rd_addr}, 32'd5);
      check("rd5_miso_byte", {24'b0, rx}, 32'hA5);
      check("rd5_hold_wr_addr", {29'b0, wr_addr}, 32'd3);
      check("rd5_hold_wr_data", {24'b0, wr_data}, 32'h40);

      // Read address 2 (model returns 0x02)
      frame(8'h02, 8'h00, 8'h00, 2, rx);
      check("rd2_miso_byte", {24'b0, rx}, 32'h02);

      // Reserved bits set
      miso_zero_en = 1'b1;
      frame(8'h8A, 8'hFF, 8'h00, 2, rx);
      check("rsvd_miso_zero", miso_viol, 32'd0);
      check("rsvd_rd_addr", {29'b0, rd_addr}, 32'd2);
      exp_q.push_back('{addr: 3'd1, data: 8'h10});
      frame(8'h81, 8'h10, 8'h00, 2, rx);
      check("wr1_pending", exp_q.size(), 32'd0);
      check("wr1_miso_zero", miso_viol, 32'd0);
      miso_zero_en = 1'b0;
      miso_viol    = 0;

      // Abort after 5 data bits
      cs = 1'b0;
      clks(HALF);
      spi_bits(8'h82, 8, rx);
      spi_bits(8'hFF, 5, rx);
      clks(HALF);
      cs = 1'b1;
      clks(20);
      check("abort_wr_data_held", {24'b0, wr_data}, 32'h10);
      exp_q.push_back('{addr: 3'd2, data: 8'h7F});
      frame(8'h82, 8'h7F, 8'h00, 2, rx);
      check("wr2_pending", exp_q.size(), 32'd0);

      // Address 7 write is dropped
      frame(8'h87, 8'h11, 8'h00, 2, rx);
      check("a7_hold_wr_addr", {29'b0, wr_addr}, 32'd2);
      check("a7_hold_wr_data", {24'b0, wr_data}, 32'h7F);

      // Trailing byte ignored
      exp_q.push_back('{addr: 3'd0, data: 8'h22});
      frame(8'h80, 8'h22, 8'h33, 3, rx);
      check("trail_pending", exp_q.size(), 32'd0);
      check("trail_wr_data", {24'b0, wr_data}, 32'h22);

      // Reset after 12 rising edges of a write frame
      cs = 1'b0;
      clks(HALF);
      spi_bits(8'h84, 8, rx);
      spi_bits(8'h55, 4, rx);
      reset = 1'b1;
      clks(3);
      check_reset_outputs("midrst");
      reset = 1'b0;
      spi_bits(8'h50, 4, rx);
      clks(HALF);
      cs = 1'b1;
      clks(20);
      check_reset_outputs("postrst");

      clks(5);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
